// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the sequence detector's serial input.
// Valid/ready word intake with a one-word holding buffer for gap-free streaming.
module seq_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic [WIDTH-1:0] sr_shifted;

    assign din_ready  = ~hold_full;
    assign accept     = din_valid & ~hold_full;
    assign sr_shifted = LSB_FIRST ? {1'b0, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sr    <= din;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        sr  <= sr_shifted;
                        cnt <= cnt + CW'(1);
                        if (accept) begin
                            hold      <= din;
                            hold_full <= 1'b1;
                        end
                    end else if (hold_full) begin
                        // din_ready is low here, so no word can arrive on this edge
                        sr        <= hold;
                        hold_full <= 1'b0;
                        cnt       <= '0;
                    end else if (accept) begin
                        sr  <= din;
                        cnt <= '0;
                    end else begin
                        sr    <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    sr    <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign x          = LSB_FIRST ? sr[0] : sr[WIDTH-1];
    assign x_valid    = (state == SHIFT);
    assign word_start = (state == SHIFT) && (cnt == '0);
    assign busy       = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: MSB-first and LSB-first instances share stimulus and
// are compared every cycle against a word/queue-level reference model.
module tb_seq_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;

    logic rdy_m, x_m, xv_m, ws_m, busy_m;
    logic rdy_l, x_l, xv_l, ws_l, busy_l;

    int checks   = 0;
    int failures = 0;

    // Reference model: current word plus bit index, and a queue of waiting words
    bit         m_active;
    logic [7:0] m_word;
    int         m_idx;
    logic [7:0] holdq[$];
    bit         last_acc;

    logic [31:0] got_m, got_l;
    int          nv, run, maxrun;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .x(x_m), .x_valid(xv_m), .word_start(ws_m), .busy(busy_m)
    );

    seq_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .x(x_l), .x_valid(xv_l), .word_start(ws_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_word   = '0;
        m_idx    = 0;
        holdq.delete();
    endtask

    task automatic model_edge(input bit acc);
        if (!m_active) begin
            if (acc) begin
                m_active = 1'b1;
                m_word   = din;
                m_idx    = 0;
            end
        end else if (m_idx == 7) begin
            if (holdq.size() != 0) begin
                m_word = holdq.pop_front();
                m_idx  = 0;
            end else if (acc) begin
                m_word = din;
                m_idx  = 0;
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_idx++;
            if (acc) holdq.push_back(din);
        end
    endtask

    task automatic check_all(input string tag);
        logic ex_m, ex_l, ews, eb, er;
        ex_m = m_active ? m_word[7 - m_idx] : 1'b0;
        ex_l = m_active ? m_word[m_idx] : 1'b0;
        ews  = m_active && (m_idx == 0);
        eb   = m_active || (holdq.size() != 0);
        er   = (holdq.size() == 0);
        chk({tag, ".x_msb"}, 32'(x_m), 32'(ex_m));
        chk({tag, ".x_lsb"}, 32'(x_l), 32'(ex_l));
        chk({tag, ".x_valid"}, {30'b0, xv_l, xv_m}, {30'b0, m_active, m_active});
        chk({tag, ".word_start"}, {30'b0, ws_l, ws_m}, {30'b0, ews, ews});
        chk({tag, ".busy"}, {30'b0, busy_l, busy_m}, {30'b0, eb, eb});
        chk({tag, ".din_ready"}, {30'b0, rdy_l, rdy_m}, {30'b0, er, er});
    endtask

    task automatic clear_stream();
        got_m  = '0;
        got_l  = '0;
        nv     = 0;
        run    = 0;
        maxrun = 0;
    endtask

    // One clock: accept decision from the model, edge, then check #1 later
    task automatic step(input string tag);
        bit acc;
        acc = din_valid && (holdq.size() == 0) && !rst;
        @(posedge clk);
        if (!rst) model_edge(acc);
        last_acc = acc;
        #1;
        check_all(tag);
        if (xv_m) begin
            got_m = {got_m[30:0], x_m};
            got_l = {got_l[30:0], x_l};
            nv++;
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all(tag);
        step(tag);
        rst = 1'b0;
    endtask

    logic [7:0] words[3];
    int         wi;

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        last_acc  = 1'b0;
        model_reset();
        clear_stream();

        repeat (3) step("reset");
        rst = 1'b0;
        repeat (20) step("idle");

        // Single word, MSB first: 1,0,1,0,1,0,0,0
        clear_stream();
        din = 8'hA8;
        din_valid = 1'b1;
        step("single");
        din_valid = 1'b0;
        repeat (12) step("single");
        chk("single_stream", got_m[7:0], 32'hA8);
        chk("single_nbits", nv, 8);
        chk("single_run", maxrun, 8);

        // Back-to-back with din_valid held high
        clear_stream();
        words = '{8'hA5, 8'h3C, 8'hFF};
        wi = 0;
        din = words[0];
        din_valid = 1'b1;
        for (int i = 0; i < 40 && wi < 3; i++) begin
            step("b2b");
            if (last_acc) begin
                wi++;
                if (wi < 3) din = words[wi];
                else din_valid = 1'b0;
            end
        end
        din_valid = 1'b0;
        chk("b2b_accepts", wi, 3);
        repeat (24) step("b2b");
        chk("b2b_stream", got_m[23:0], 32'hA53CFF);
        chk("b2b_nbits", nv, 24);
        chk("b2b_run", maxrun, 24);

        // LSB first: 8'h15 -> 1,0,1,0,1,0,0,0
        clear_stream();
        din = 8'h15;
        din_valid = 1'b1;
        step("lsb");
        din_valid = 1'b0;
        repeat (12) step("lsb");
        chk("lsb_stream", got_l[7:0], 32'hA8);

        // Reset mid-word with a word waiting in the holding register
        din = 8'hAA;
        din_valid = 1'b1;
        step("midrst");
        din = 8'h55;
        step("midrst");
        din_valid = 1'b0;
        chk("midrst_held", holdq.size(), 1);
        step("midrst");
        step("midrst");
        async_reset("midrst_async");
        clear_stream();
        repeat (15) step("midrst_after");
        chk("midrst_no_bits", nv, 0);

        // Late refill exactly on the last-bit edge
        clear_stream();
        din = 8'h3C;
        din_valid = 1'b1;
        step("late");
        din_valid = 1'b0;
        for (int i = 0; i < 20 && !(m_active && m_idx == 7); i++) step("late");
        chk("late_reached_last", {31'b0, m_active && m_idx == 7}, 32'd1);
        din = 8'hC3;
        din_valid = 1'b1;
        step("late");
        din_valid = 1'b0;
        repeat (12) step("late");
        chk("late_stream", got_m[15:0], 32'h3CC3);
        chk("late_run", maxrun, 16);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            din       = 8'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) async_reset("rand_rst");
            else step("rand");
        end
        din_valid = 1'b0;
        repeat (20) step("drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial stage that drives the single-bit serial input `x` of the sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, with a one-word holding buffer so back-to-back words stream with no idle gap. While no word is being shifted, the block drives `x` to 0, which the detector treats as a benign idle bit.

## Interface
- `WIDTH`, default 8: bits per word, 2..32.
- `LSB_FIRST`, default 0: 0 = MSB shifted first; 1 = LSB shifted first.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  WIDTH  parallel word.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can accept a word this cycle.
- `x`  out  1  serial bit to the detector, registered.
- `x_valid`  out  1  `x` carries a data bit, not idle fill.
- `word_start`  out  1  high during the first bit of each word.
- `busy`  out  1  shifter active or holding buffer full.

## Operation
- Handshake: a word is accepted on a rising edge where `din_valid && din_ready`. `din_ready` = NOT hold_full, and depends on register state only, with no combinational path from `din_valid`. Upstream may hold `din_valid` high indefinitely.
- Storage: shift register `sr[WIDTH-1:0]`, bit counter `cnt` (0..WIDTH-1), holding register plus `hold_full` flag.
- FSM states:
  - IDLE: `sr`=0, `x`=0, `x_valid`=0.
  - SHIFT: a word is being output.
- Transitions and loads:
  - IDLE, accept → load `din` into `sr`, `cnt`=0, go to SHIFT. The holding register is empty in IDLE.
  - SHIFT, `cnt`<WIDTH-1 → shift `sr` by one position toward the output end and increment `cnt`. An accepted word goes into the holding register and sets `hold_full`.
  - SHIFT, `cnt`==WIDTH-1 (last-bit edge), in priority order:
    - `hold_full` → move the holding register into `sr`, clear `hold_full`, `cnt`=0, stay in SHIFT. `din_ready` was 0, so no accept is possible on this edge.
    - else accept → load `din` directly into `sr`, `cnt`=0, stay in SHIFT.
    - else → `sr`=0, go to IDLE.
- Output: `x` = `sr[WIDTH-1]` if LSB_FIRST=0, else `sr[0]`. Shift direction follows the same parameter.
- `x_valid` = (state==SHIFT). `word_start` = SHIFT && `cnt`==0. `busy` = SHIFT || `hold_full`.
- Unused `sr` bits fill with 0 on shift.
- Reset (asynchronous, any time including mid-word):
  - state=IDLE, `sr`=0, `cnt`=0, `hold_full`=0.
  - Outputs: `x`=0, `x_valid`=0, `word_start`=0, `busy`=0, `din_ready`=1.
  - Partial and held words are discarded with no resumption.

## Timing
- Latency: a word accepted at edge k from IDLE puts its first bit on `x` in the cycle after edge k. Its last bit appears in the cycle after edge k+WIDTH-1.
- Throughput: one bit per clock, and contiguous words leave no gap between them.
- `x_valid` stays high continuously as long as a word is always available by the last-bit edge.
- `din_ready`:
  - Falls the cycle after a word enters the holding register.
  - Rises the cycle after the holding register drains into `sr`.
- Simultaneous events:
  - An accept on the last-bit edge with the holding register empty loads directly, so the holding register stays empty.
  - Reset overrides every other event.

## Test plan
- Reset/idle: assert `rst`, release, hold `din_valid`=0 for 20 cycles → `x`=0, `x_valid`=0, `word_start`=0, `busy`=0, `din_ready`=1 throughout.
- Single word, WIDTH=8, MSB first: `din`=8'b10101000 for one cycle → `x` = 1,0,1,0,1,0,0,0 on 8 consecutive cycles, with `x_valid` high for exactly those 8 cycles and `word_start` high on the first. A detector connected to `x` pulses `z` during the 6th bit.
- Back-to-back: `din_valid` held high with 8'hA5, 8'h3C, 8'hFF → 24 contiguous `x_valid` cycles with `word_start` on cycles 1, 9 and 17. `din_ready` is low while the holding register is full, and the bit stream equals A5,3C,FF MSB-first.
- LSB_FIRST=1: `din`=8'h15 → `x` = 1,0,1,0,1,0,0,0.
- Reset mid-operation: accept 8'hAA, accept 8'h55 into the holding register, then assert `rst` on bit 3 → the next cycle `x`=0, `x_valid`=0, `busy`=0, `din_ready`=1. No bits of 8'h55 are ever output.
- Late refill: accept a word on the last-bit edge of the previous word with the holding register empty → no gap cycle, the new word's first bit follows immediately, and `hold_full` stays 0.
